// File: rtl/cac_pkg.sv
// Shared types and constants for the corrupt-and-correct sequential lock.
// Optional lockout feature is selected with the CAC_LOCKOUT_EN macro.
package cac_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        CHECK   = 2'd1,
        LOCKOUT = 2'd2
    } cac_state_e;

    localparam logic [31:0] CAC_SECRET_DEFAULT = 32'hA5C3_0F96;

    // Number of load beats needed to assemble one key.
    function automatic int unsigned cac_beats(input int unsigned key_w, input int unsigned chunk_w);
        return key_w / chunk_w;
    endfunction

endpackage

// File: rtl/cac_key_loader.sv
// Key staging loader: beat counter, MSB-first shift register and framing check.
// commit pulses on a correctly framed final beat; err pulses on a misplaced or missing key_last.
module cac_key_loader
    import cac_pkg::*;
#(
    parameter int unsigned KEY_W   = 32,
    parameter int unsigned CHUNK_W = 8
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               accept,
    input  logic [CHUNK_W-1:0] data,
    input  logic               last,
    output logic [KEY_W-1:0]   staging,
    output logic               commit,
    output logic               err
);

    localparam int unsigned BEATS = cac_beats(KEY_W, CHUNK_W);
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0] beat_cnt;
    logic             at_last;

    assign at_last = (beat_cnt == LAST_IDX);
    assign commit  = accept && last && at_last;
    assign err     = accept && (last != at_last);

    // Shift accepted beats into staging; a framing error discards the partial key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            staging  <= '0;
        end else if (accept) begin
            if (err) begin
                beat_cnt <= '0;
                staging  <= '0;
            end else begin
                staging  <= (staging << CHUNK_W) | KEY_W'(data);
                beat_cnt <= at_last ? '0 : beat_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cac_seq_lock.sv
// Sequential corrupt-and-correct lock: chunked key load with atomic commit,
// 2-stage perturb/restore evaluation pipeline, optional wrong-key lockout.
// Define CAC_LOCKOUT_EN to enable the wrong-commit counter and LOCKOUT state.
module cac_seq_lock
    import cac_pkg::*;
#(
    parameter int unsigned       KEY_W    = 32,
    parameter int unsigned       CHUNK_W  = 8,
    parameter logic [KEY_W-1:0]  SECRET   = KEY_W'(CAC_SECRET_DEFAULT),
    parameter int unsigned       MAX_FAIL = 3
)(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           key_valid,
    output logic                           key_ready,
    input  logic [CHUNK_W-1:0]             key_data,
    input  logic                           key_last,
    output logic                           key_err,
    input  logic                           in_valid,
    input  logic [KEY_W-1:0]               pat_in,
    input  logic                           func_in,
    output logic                           out_valid,
    output logic                           out_bit,
    output logic                           unlocked,
    output logic                           locked_out,
    output logic [$clog2(MAX_FAIL+1)-1:0]  fail_cnt
);

    localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

    generate
        if ((KEY_W % CHUNK_W) != 0) begin : g_bad_chunk
            $error("cac_seq_lock: KEY_W must be a multiple of CHUNK_W");
        end
        if (MAX_FAIL < 1) begin : g_bad_max_fail
            $error("cac_seq_lock: MAX_FAIL must be at least 1");
        end
    endgenerate

    cac_state_e       state;
    cac_state_e       state_nxt;
    logic [KEY_W-1:0] staging;
    logic [KEY_W-1:0] key_reg;
    logic             accept;
    logic             ld_commit;
    logic             ld_err;
    logic             key_ok;
    logic             commit_en;
    logic             unlocked_q;
    logic             fail_hit;

    logic             s1_valid;
    logic             s1_perturb;
    logic             s1_restore;
    logic             s1_func;

    assign key_ready = (state == LOAD);
    assign accept    = key_valid & key_ready;
    assign key_ok    = (staging == SECRET);
    assign unlocked  = unlocked_q & ~locked_out;

    cac_key_loader #(
        .KEY_W   (KEY_W),
        .CHUNK_W (CHUNK_W)
    ) u_loader (
        .clk     (clk),
        .rst_n   (rst_n),
        .accept  (accept),
        .data    (key_data),
        .last    (key_last),
        .staging (staging),
        .commit  (ld_commit),
        .err     (ld_err)
    );

`ifdef CAC_LOCKOUT_EN
    logic fail_evt;

    // Both framing errors and wrong commits count as failed attempts.
    assign fail_evt   = ((state == LOAD) && ld_err) || ((state == CHECK) && !key_ok);
    assign fail_hit   = fail_evt && (fail_cnt == FAIL_W'(MAX_FAIL - 1));
    assign locked_out = (state == LOCKOUT);

    // Saturating wrong-attempt counter; a correct commit leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt <= '0;
        end else if (fail_evt && (fail_cnt != FAIL_W'(MAX_FAIL))) begin
            fail_cnt <= fail_cnt + FAIL_W'(1);
        end
    end
`else
    assign fail_hit   = 1'b0;
    assign fail_cnt   = '0;
    assign locked_out = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and commit control.
    always_comb begin
        state_nxt = state;
        commit_en = 1'b0;
        unique case (state)
            LOAD: begin
                if (ld_commit) begin
                    state_nxt = CHECK;
                end else if (fail_hit) begin
                    state_nxt = LOCKOUT;
                end
            end
            CHECK: begin
                commit_en = 1'b1;
                state_nxt = fail_hit ? LOCKOUT : LOAD;
            end
            LOCKOUT: begin
                state_nxt = LOCKOUT;
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // Committed key, unlock flag and registered framing-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg    <= '0;
            unlocked_q <= 1'b0;
            key_err    <= 1'b0;
        end else begin
            key_err <= ld_err;
            if (commit_en) begin
                key_reg    <= staging;
                unlocked_q <= key_ok;
            end
        end
    end

    // Evaluation stage 1: pattern compares against secret and committed key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_perturb <= 1'b0;
            s1_restore <= 1'b0;
            s1_func    <= 1'b0;
        end else begin
            s1_valid   <= in_valid;
            s1_perturb <= (pat_in == SECRET);
            s1_restore <= (pat_in == key_reg) & ~locked_out;
            s1_func    <= func_in;
        end
    end

    // Evaluation stage 2: combine flips into the protected output bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_bit <= s1_func ^ s1_perturb ^ s1_restore;
            end
        end
    end

endmodule

// File: tb/tb_cac_seq_lock.sv
// Scoreboard bench for cac_seq_lock: directed scenarios plus randomized traffic
// checked against a behavioural key/lockout model kept in the bench.
module tb_cac_seq_lock;

    localparam int unsigned KEY_W    = 32;
    localparam int unsigned CHUNK_W  = 8;
    localparam int unsigned MAX_FAIL = 3;
    localparam int unsigned BEATS    = KEY_W / CHUNK_W;
    localparam logic [31:0] SECRET   = 32'hA5C3_0F96;
`ifdef CAC_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        key_valid = 1'b0;
    logic [7:0]  key_data = '0;
    logic        key_last = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] pat_in = '0;
    logic        func_in = 1'b0;
    logic        key_ready, key_err, out_valid, out_bit, unlocked, locked_out;
    logic [1:0]  fail_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    typedef struct {
        bit b;
        int due;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state
    logic [31:0] m_key;
    logic [31:0] m_stage;
    int          m_nbeats;
    int          m_fail;
    bit          m_unlocked, m_locked, m_pending, m_err;

    cac_seq_lock #(
        .KEY_W    (KEY_W),
        .CHUNK_W  (CHUNK_W),
        .SECRET   (SECRET),
        .MAX_FAIL (MAX_FAIL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_data   (key_data),
        .key_last   (key_last),
        .key_err    (key_err),
        .in_valid   (in_valid),
        .pat_in     (pat_in),
        .func_in    (func_in),
        .out_valid  (out_valid),
        .out_bit    (out_bit),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (errors so far %0d)", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_key = '0; m_stage = '0; m_nbeats = 0; m_fail = 0;
        m_unlocked = 0; m_locked = 0; m_pending = 0; m_err = 0;
    endtask

    task automatic m_wrong();
        if (LOCK_EN) begin
            if (m_fail < MAX_FAIL) m_fail++;
            if (m_fail == MAX_FAIL) m_locked = 1;
        end
    endtask

    // One clock: record expected eval result, advance model over the edge, drop valids.
    task automatic tick();
        bit   rdy;
        exp_t e;
        rdy = !m_locked && !m_pending;
        if (in_valid) begin
            e.b   = func_in ^ (pat_in == SECRET) ^ ((pat_in == m_key) && !m_locked);
            e.due = cyc + 2;
            exp_q.push_back(e);
        end
        @(posedge clk);
        m_err = 0;
        if (m_pending) begin
            m_key      = m_stage;
            m_unlocked = (m_stage == SECRET);
            if (!m_unlocked) m_wrong();
            m_pending  = 0;
            m_nbeats   = 0;
        end else if (key_valid && rdy) begin
            m_stage = (m_stage << 8) | 32'(key_data);
            m_nbeats++;
            if (key_last && m_nbeats == BEATS) begin
                m_pending = 1;
            end else if (key_last || m_nbeats == BEATS) begin
                m_err = 1; m_nbeats = 0; m_stage = '0;
                m_wrong();
            end
        end
        #1;
        key_valid = 0; key_last = 0; in_valid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        m_reset();
        exp_q.delete();
        #2;
        chk("rst_out_bit", out_bit, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic eval(input logic [31:0] p, input logic f);
        in_valid = 1; pat_in = p; func_in = f;
        tick();
    endtask

    // last_at: beat index carrying key_last (BEATS-1 normal, earlier = error, -1 = missing)
    task automatic load_key(input logic [31:0] k, input int last_at);
        for (int i = 0; i < int'(BEATS); i++) begin
            key_valid = 1;
            key_data  = k[31 - 8*i -: 8];
            key_last  = (i == last_at);
            tick();
            if (i == last_at) break;
        end
    endtask

    // Monitor: pops expected results when due; also tracks status outputs each cycle.
    always @(negedge clk) begin
        bit   ev;
        exp_t e;
        if (mon_en) begin
            ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("out_valid", out_valid, ev);
            if (ev) begin
                e = exp_q.pop_front();
                if (out_valid) chk("out_bit", out_bit, e.b);
            end
            while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
            chk("key_ready", key_ready, !m_locked && !m_pending);
            chk("key_err", key_err, m_err);
            chk("unlocked", unlocked, m_unlocked && !m_locked);
            chk("locked_out", locked_out, m_locked);
            chk("fail_cnt", fail_cnt, m_fail);
        end
    end

    initial begin
        logic [31:0] target;
        m_reset();
        target = SECRET;
        #1;
        do_reset();
        mon_en = 1;

        // Correct key then eval at the protected pattern
        load_key(SECRET, BEATS - 1);
        idle(1);
        chk("unlock_correct", unlocked, 1'b1);
        eval(SECRET, 1'b1);
        idle(3);

        // Wrong key 1: corrupted at SECRET and at the key pattern
        load_key(32'h0000_0001, BEATS - 1);
        idle(1);
        eval(SECRET, 1'b0);
        eval(32'h0000_0001, 1'b0);
        eval(32'h0000_0002, 1'b0);
        idle(3);

        // Early key_last: framing error, committed key unchanged
        load_key(SECRET, 1);
        idle(1);
        eval(32'h0000_0001, 1'b0);
        idle(3);

        // Eval in the CHECK cycle uses the old key; next cycle uses the new one
        do_reset();
        load_key(32'h0BAD_F00D, BEATS - 1);
        idle(1);
        load_key(SECRET, BEATS - 1);
        eval(SECRET, 1'b0);
        eval(SECRET, 1'b0);
        eval(32'h0BAD_F00D, 1'b1);
        idle(3);

        // Randomized traffic with periodic resets
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 49) do_reset();
            if ($urandom_range(0, 1) == 1) begin
                if (m_nbeats == 0) target = ($urandom_range(0, 1) == 1) ? SECRET : 32'($urandom);
                key_valid = 1;
                key_data  = target[31 - 8*(m_nbeats % BEATS) -: 8];
                key_last  = ((m_nbeats % BEATS) == BEATS - 1);
                if ($urandom_range(0, 7) == 0) key_last = !key_last;
            end
            if ($urandom_range(0, 1) == 1) begin
                in_valid = 1;
                func_in  = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0: pat_in = SECRET;
                    1: pat_in = m_key;
                    2: pat_in = target;
                    default: pat_in = 32'($urandom);
                endcase
            end
            tick();
        end
        idle(3);

`ifdef CAC_LOCKOUT_EN
        // Three wrong keys lock the unit until reset
        do_reset();
        load_key(32'h1111_1111, BEATS - 1);
        idle(1);
        load_key(32'h2222_2222, BEATS - 1);
        idle(1);
        load_key(32'h3333_3333, BEATS - 1);
        idle(1);
        chk("lockout_flag", locked_out, 1'b1);
        chk("lockout_ready", key_ready, 1'b0);
        load_key(SECRET, BEATS - 1);
        idle(1);
        chk("lockout_unlocked", unlocked, 1'b0);
        eval(SECRET, 1'b0);
        eval(32'h3333_3333, 1'b1);
        idle(3);
        do_reset();
        chk("post_rst_locked", locked_out, 1'b0);
        chk("post_rst_fail", fail_cnt, 2'd0);
        chk("post_rst_ready", key_ready, 1'b1);
`else
        // Unlimited retries without the lockout feature
        do_reset();
        for (int i = 0; i < 10; i++) begin
            load_key(32'h1000_0000 + 32'(i), BEATS - 1);
            idle(1);
        end
        load_key(SECRET, BEATS - 1);
        idle(1);
        chk("retry_unlocked", unlocked, 1'b1);
        chk("retry_locked", locked_out, 1'b0);
        chk("retry_fail", fail_cnt, 2'd0);
`endif
        idle(4);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
